// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// A word is accepted over a 4-phase req/ack handshake.
// It is then sent on xmt as: start bit, DATA_W data bits, an optional parity
// bit, and STOP_BITS stop bits. Every bit lasts DIV clocks.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits. The parity bit is ^data ^ parity_odd, both captured at acceptance.
module uart_tx_param #(
  parameter int DATA_W    = 8,
  parameter int DIV       = 580,
  parameter int STOP_BITS = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  input  logic              parity_odd,
  output logic              xmt,
  output logic              ack,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int TMR_W = $clog2(DIV);

  // Reject configurations the datapath was not sized for
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: DIV must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, HS_ACK, HS_REL, START, DATA, PARITY, STOP} state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  data_reg;
  logic               par_bit;
  logic               bit_end;

  // Returns data bit number i in transmission order
  function automatic logic pick(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] p;
    p = (MSB_FIRST != 0) ? IDX_W'(DATA_W - 1) - i : i;
    return w[p];
  endfunction

  assign bit_end = (timer == TMR_W'(DIV - 1));

  // The word is captured only at the IDLE->HS_ACK edge and is stable after that
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      data_reg <= data;
`ifdef UART_TX_PARITY_EN
      par_bit  <= ^data ^ parity_odd;
`else
      par_bit  <= 1'b0;
`endif
    end
  end

`ifndef UART_TX_PARITY_EN
  logic unused_parity;
  assign unused_parity = parity_odd ^ par_bit;
`endif

  // Handshake and frame sequencer; xmt, ack and busy are registered here
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      xmt   <= 1'b1;
      ack   <= 1'b0;
      busy  <= 1'b0;
      timer <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            ack   <= 1'b1;
            busy  <= 1'b1;
            state <= HS_ACK;
          end
        end
        HS_ACK: begin
          if (!req) begin
            ack   <= 1'b0;
            state <= HS_REL;
          end
        end
        HS_REL: begin
          timer <= '0;
          xmt   <= 1'b0;
          state <= START;
        end
        START: begin
          if (bit_end) begin
            timer <= '0;
            idx   <= '0;
            xmt   <= pick(data_reg, '0);
            state <= DATA;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (idx == IDX_W'(DATA_W - 1)) begin
              idx   <= '0;
`ifdef UART_TX_PARITY_EN
              xmt   <= par_bit;
              state <= PARITY;
`else
              xmt   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
              xmt <= pick(data_reg, idx + IDX_W'(1));
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            timer <= '0;
            xmt   <= 1'b1;
            state <= STOP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (idx == IDX_W'(STOP_BITS - 1)) begin
              idx   <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          xmt   <= 1'b1;
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
